// File: rtl/reorder_tag_manager.sv
// reorder_tag_manager: allocates reorder tags, records per-tag verdicts
// and serves per-tag status to the downstream circular buffer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tag_req/tag_gnt   ingress tag request / grant, tag_alloc = granted tag
//   verdict_*         filter verdict (valid, tag, accept)
//   reorder_tag_out   tag being drained by the buffer
//   packet_status     00 pending/free, 01 rejected, 11 accepted
//   release_valid     buffer finished its oldest packet
//   in_flight         allocated tag count
//   full, empty       occupancy flags
//   err               sticky protocol-error flag
module reorder_tag_manager #(
  parameter int TAG_WIDTH = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  localparam int CNT_WIDTH = $clog2(CIRCULAR_BUFFER_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tag_req,
  output logic                 tag_gnt,
  output logic [TAG_WIDTH-1:0] tag_alloc,
  input  logic                 verdict_valid,
  input  logic [TAG_WIDTH-1:0] verdict_tag,
  input  logic                 verdict_accept,
  input  logic [TAG_WIDTH-1:0] reorder_tag_out,
  output logic [1:0]           packet_status,
  input  logic                 release_valid,
  output logic [CNT_WIDTH-1:0] in_flight,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam int DEPTH = 1 << TAG_WIDTH;

  localparam logic [TAG_WIDTH-1:0] LAST =
    TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);

  localparam logic [TAG_WIDTH:0] TAG_LIM =
    (TAG_WIDTH + 1)'(CIRCULAR_BUFFER_SIZE);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL =
    CNT_WIDTH'(CIRCULAR_BUFFER_SIZE);

  // Decided states encode their own status code; PENDING and
  // FREE both report 00.
  typedef enum logic [1:0] {
    E_FREE = 2'b00,
    E_PEND = 2'b10,
    E_REJ  = 2'b01,
    E_ACC  = 2'b11
  } entry_e;

  // Table spans the full tag space so any tag indexes it
  // directly; entries at or above the size are never written.
  entry_e               tbl [DEPTH];
  logic [TAG_WIDTH-1:0] alloc_ptr;
  logic [TAG_WIDTH-1:0] rel_ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 err_q;

  logic   rot_in;
  entry_e rot_e;
  logic   v_in;
  logic   v_ok;
  logic   v_bad;
  logic   r_ok;
  logic   r_hit;
  logic   r_bad;

  function automatic logic [TAG_WIDTH-1:0] nxt(
    input logic [TAG_WIDTH-1:0] p
  );
    return (p == LAST) ? '0 : p + TAG_WIDTH'(1);
  endfunction

  assign full      = (cnt == CNT_FULL);
  assign empty     = (cnt == '0);
  assign tag_gnt   = tag_req & ~full;
  assign tag_alloc = alloc_ptr;
  assign in_flight = cnt;
  assign err       = err_q;

  assign rot_in = {1'b0, reorder_tag_out} < TAG_LIM;
  assign rot_e  = tbl[reorder_tag_out];

  always_comb begin
    packet_status = 2'b00;
    if (rot_in && rot_e != E_PEND)
      packet_status = rot_e;
  end

  assign v_in  = {1'b0, verdict_tag} < TAG_LIM;
  assign v_ok  = verdict_valid & v_in
               & (tbl[verdict_tag] == E_PEND);
  assign v_bad = verdict_valid & ~v_ok;

  // A verdict landing on the entry being released in the same
  // cycle resolves it, so that release is not premature.
  assign r_ok  = release_valid & ~empty;
  assign r_hit = v_ok & (verdict_tag == rel_ptr);
  assign r_bad = release_valid
               & (empty
                  | ((tbl[rel_ptr] == E_PEND) & ~r_hit));

  // Write order matters: verdict, then release (later write wins
  // on a shared index), then grant to a FREE slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl       <= '{default: E_FREE};
      alloc_ptr <= '0;
      rel_ptr   <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else begin
      if (v_ok)
        tbl[verdict_tag] <= verdict_accept ? E_ACC : E_REJ;
      if (r_ok) begin
        tbl[rel_ptr] <= E_FREE;
        rel_ptr      <= nxt(rel_ptr);
      end
      if (tag_gnt) begin
        tbl[alloc_ptr] <= E_PEND;
        alloc_ptr      <= nxt(alloc_ptr);
      end
      unique case ({tag_gnt, r_ok})
        2'b10:   cnt <= cnt + CNT_WIDTH'(1);
        2'b01:   cnt <= cnt - CNT_WIDTH'(1);
        default: cnt <= cnt;
      endcase
      if (v_bad | r_bad)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reorder_tag_manager.sv
// tb_reorder_tag_manager: directed plus random checks of
// reorder_tag_manager against a queue-based model, SIZE=3.
module tb_reorder_tag_manager;

  localparam int TW = 6;
  localparam int SZ = 3;
  localparam int CW = $clog2(SZ + 1);

  localparam int F = 0;
  localparam int P = 1;
  localparam int R = 2;
  localparam int A = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          tag_req;
  logic          tag_gnt;
  logic [TW-1:0] tag_alloc;
  logic          verdict_valid;
  logic [TW-1:0] verdict_tag;
  logic          verdict_accept;
  logic [TW-1:0] reorder_tag_out;
  logic [1:0]    packet_status;
  logic          release_valid;
  logic [CW-1:0] in_flight;
  logic          full;
  logic          empty;
  logic          err;

  always #5 clk = ~clk;

  reorder_tag_manager #(
    .TAG_WIDTH(TW),
    .CIRCULAR_BUFFER_SIZE(SZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tag_req(tag_req),
    .tag_gnt(tag_gnt),
    .tag_alloc(tag_alloc),
    .verdict_valid(verdict_valid),
    .verdict_tag(verdict_tag),
    .verdict_accept(verdict_accept),
    .reorder_tag_out(reorder_tag_out),
    .packet_status(packet_status),
    .release_valid(release_valid),
    .in_flight(in_flight),
    .full(full),
    .empty(empty),
    .err(err)
  );

  int st [SZ];
  int q [$];
  int nxt_tag;
  bit m_err;
  bit m_ok = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int exp_status(int t);
    if (t >= SZ) return 0;
    if (st[t] == R) return 1;
    if (st[t] == A) return 3;
    return 0;
  endfunction

  task automatic compare_all();
    if (!m_ok) return;
    chk("gnt", 32'(tag_gnt),
        32'(tag_req && q.size() < SZ));
    chk("alloc", 32'(tag_alloc), 32'(nxt_tag));
    chk("status", 32'(packet_status),
        32'(exp_status(int'(reorder_tag_out))));
    chk("in_flight", 32'(in_flight), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == SZ));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic drive(bit r, bit rq, bit vv, int vt,
                       bit va, bit rl, int rot);
    rst             = r;
    tag_req         = rq;
    verdict_valid   = vv;
    verdict_tag     = TW'(vt);
    verdict_accept  = va;
    release_valid   = rl;
    reorder_tag_out = TW'(rot);
    #1;
    compare_all();
  endtask

  task automatic idle(int rot);
    drive(0, 0, 0, 0, 0, 0, rot);
  endtask

  task automatic tick();
    bit g;
    int t;
    int vt;
    if (rst) begin
      foreach (st[i]) st[i] = F;
      q.delete();
      nxt_tag = 0;
      m_err   = 0;
      m_ok    = 1;
    end else begin
      g  = tag_req && q.size() < SZ;
      vt = int'(verdict_tag);
      if (verdict_valid) begin
        if (vt < SZ && st[vt] == P)
          st[vt] = verdict_accept ? A : R;
        else
          m_err = 1;
      end
      if (release_valid) begin
        if (q.size() == 0) begin
          m_err = 1;
        end else begin
          t = q.pop_front();
          if (st[t] == P) m_err = 1;
          st[t] = F;
        end
      end
      if (g) begin
        st[nxt_tag] = P;
        q.push_back(nxt_tag);
        nxt_tag = (nxt_tag + 1) % SZ;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic reset_lits(string pfx);
    chk({pfx, "_empty"}, 32'(empty), 32'd1);
    chk({pfx, "_full"}, 32'(full), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
    chk({pfx, "_alloc"}, 32'(tag_alloc), 32'd0);
    chk({pfx, "_gnt"}, 32'(tag_gnt), 32'd0);
    chk({pfx, "_status"}, 32'(packet_status), 32'd0);
    chk({pfx, "_cnt"}, 32'(in_flight), 32'd0);
  endtask

  initial begin
    int vt;
    @(negedge clk);
    do_reset();
    idle(0);
    reset_lits("rst0");
    tick();

    // allocation up to full
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      if (i < 3) begin
        chk("alloc_gnt", 32'(tag_gnt), 32'd1);
        chk("alloc_tag", 32'(tag_alloc), 32'(i));
      end else begin
        chk("full_gnt", 32'(tag_gnt), 32'd0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_cnt", 32'(in_flight), 32'd3);
      end
      tick();
    end

    // verdict visibility
    drive(0, 0, 1, 1, 1, 0, 1);
    chk("vis_pre", 32'(packet_status), 32'd0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 1);
    chk("vis_acc", 32'(packet_status), 32'd3);
    tick();
    idle(0);
    chk("vis_rej", 32'(packet_status), 32'd1);
    idle(2);
    chk("vis_pend", 32'(packet_status), 32'd0);
    idle(1);
    chk("vis_acc2", 32'(packet_status), 32'd3);
    tick();

    // full: release + request gives no bypass grant
    drive(0, 1, 0, 0, 0, 1, 0);
    chk("nobypass", 32'(tag_gnt), 32'd0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_gnt", 32'(tag_gnt), 32'd1);
    chk("wrap_tag", 32'(tag_alloc), 32'd0);
    tick();
    idle(0);
    chk("wrap_cnt", 32'(in_flight), 32'd3);

    // verdict tag 2 while releasing tag 1, then grant+release
    drive(0, 0, 1, 2, 1, 1, 0);
    tick();
    drive(0, 1, 0, 0, 0, 1, 0);
    chk("gr_gnt", 32'(tag_gnt), 32'd1);
    chk("gr_tag", 32'(tag_alloc), 32'd1);
    tick();
    idle(0);
    chk("gr_cnt", 32'(in_flight), 32'd2);
    chk("gr_err", 32'(err), 32'd0);
    tick();

    // reset mid-operation
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 1, 0, 0);
    tick();
    drive(0, 0, 1, 5, 1, 0, 0);
    tick();
    idle(0);
    chk("mid_err", 32'(err), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    reset_lits("mid");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("mid_tag", 32'(tag_alloc), 32'd0);
    tick();

    // verdict on a FREE tag
    do_reset();
    drive(0, 0, 1, 1, 1, 0, 1);
    tick();
    idle(1);
    chk("free_err", 32'(err), 32'd1);
    chk("free_st", 32'(packet_status), 32'd0);

    // second verdict on a decided tag
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 1, 0, 0);
    tick();
    idle(0);
    chk("dbl_err0", 32'(err), 32'd0);
    drive(0, 0, 1, 0, 0, 0, 0);
    tick();
    idle(0);
    chk("dbl_err", 32'(err), 32'd1);
    chk("dbl_st", 32'(packet_status), 32'd3);

    // release while empty
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    idle(0);
    chk("emp_err", 32'(err), 32'd1);
    chk("emp_cnt", 32'(in_flight), 32'd0);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (q.size() != 0 && $urandom_range(0, 9) < 8)
        vt = q[$urandom_range(0, q.size() - 1)];
      else if ($urandom_range(0, 3) == 0)
        vt = 63;
      else
        vt = $urandom_range(0, 3);
      drive($urandom_range(0, 59) == 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0,
            vt,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 4));
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
